// File: rtl/reg_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard_if
// Description : Issue/retire/flush handshake and status bundle between the
//               decode-side pipeline stages and the register scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_scoreboard_if #(
    parameter int NREGS = 16,
    parameter int IDXW  = 4,
    parameter int CNTW  = 3,
    parameter int NSRC  = 2
);
    logic                   issue_valid;
    logic                   issue_wr;
    logic [IDXW-1:0]        issue_rt;
    logic [NSRC-1:0]        src_valid;
    logic [NSRC*IDXW-1:0]   src_idx;
    logic                   retire_valid;
    logic [IDXW-1:0]        retire_rt;
    logic                   flush;
    logic                   stall;
    logic                   issue_accept;
    logic [NREGS-1:0]       busy_mask;
    logic [IDXW+CNTW-1:0]   pending;
    logic                   underflow_err;

    modport master (
        output issue_valid, issue_wr, issue_rt, src_valid, src_idx,
               retire_valid, retire_rt, flush,
        input  stall, issue_accept, busy_mask, pending, underflow_err
    );

    modport slave (
        input  issue_valid, issue_wr, issue_rt, src_valid, src_idx,
               retire_valid, retire_rt, flush,
        output stall, issue_accept, busy_mask, pending, underflow_err
    );
endinterface
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Per-register in-flight writer counters with decode stall,
//               saturation, sticky underflow flag and total occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
    parameter int NREGS = 16,
    parameter int IDXW  = 4,
    parameter int CNTW  = 3,
    parameter int NSRC  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    reg_scoreboard_if.slave   sb
);
    localparam int              PW         = IDXW + CNTW;
    localparam logic [CNTW-1:0] C_CNT_MAX  = '1;
    localparam logic [CNTW-1:0] C_CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]   C_PEND_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [NREGS-1:0] w_issue_sel;
    logic [NREGS-1:0] w_retire_sel;
    logic [NREGS-1:0] w_busy;
    logic [NREGS-1:0] w_sat;
    logic [NREGS-1:0] w_inc;
    logic [NREGS-1:0] w_dec;
    logic [NSRC-1:0]  w_src_hit;
    logic             w_stall;
    logic             w_accept;
    logic             w_underflow;
    logic [PW-1:0]    r_pending;
    logic             r_underflow;

    // Decoders only match 1..NREGS-1, so r0 and out-of-range indices never hit
    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        if (r == 0) begin : g_r0
            assign w_issue_sel[r]  = 1'b0;
            assign w_retire_sel[r] = 1'b0;
            assign w_busy[r]       = 1'b0;
            assign w_sat[r]        = 1'b0;
        end else begin : g_rn
            logic [CNTW-1:0] r_count;

            assign w_issue_sel[r]  = (sb.issue_rt  == IDXW'(r));
            assign w_retire_sel[r] = (sb.retire_rt == IDXW'(r));
            assign w_busy[r]       = (r_count != '0);
            assign w_sat[r]        = (r_count == C_CNT_MAX);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_count <= '0;
                end else if (sb.flush) begin
                    r_count <= '0;
                end else if (w_inc[r] && !w_dec[r]) begin
                    r_count <= r_count + C_CNT_ONE;
                end else if (w_dec[r] && !w_inc[r]) begin
                    r_count <= r_count - C_CNT_ONE;
                end
            end
        end
    end

    for (genvar k = 0; k < NSRC; k++) begin : g_src
        logic [NREGS-1:0] w_src_sel;
        for (genvar r = 0; r < NREGS; r++) begin : g_sel
            assign w_src_sel[r] = (r != 0) && (sb.src_idx[k*IDXW +: IDXW] == IDXW'(r));
        end
        assign w_src_hit[k] = sb.src_valid[k] & (|(w_src_sel & w_busy));
    end

    assign w_stall     = sb.issue_valid &
                         ((|w_src_hit) | (sb.issue_wr & (|(w_issue_sel & w_sat))));
    assign w_accept    = sb.issue_valid & ~w_stall;
    assign w_inc       = {NREGS{w_accept & sb.issue_wr}} & w_issue_sel;
    assign w_dec       = {NREGS{sb.retire_valid}} & w_retire_sel & w_busy;
    assign w_underflow = sb.retire_valid & (|(w_retire_sel & ~w_busy));

    // At most one increment and one decrement per cycle, so the total moves by one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else if (sb.flush) begin
            r_pending <= '0;
        end else if ((|w_inc) && !(|w_dec)) begin
            r_pending <= r_pending + C_PEND_ONE;
        end else if ((|w_dec) && !(|w_inc)) begin
            r_pending <= r_pending - C_PEND_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underflow <= 1'b0;
        end else if (w_underflow) begin
            r_underflow <= 1'b1;
        end
    end

    assign sb.stall         = w_stall;
    assign sb.issue_accept  = w_accept;
    assign sb.busy_mask     = w_busy;
    assign sb.pending       = r_pending;
    assign sb.underflow_err = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_scoreboard
// Description : Directed and randomized checks of reg_scoreboard against a
//               per-register count model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_scoreboard;
    localparam int NREGS = 16;
    localparam int IDXW  = 4;
    localparam int CNTW  = 3;
    localparam int NSRC  = 2;
    localparam int MAXC  = (1 << CNTW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_scoreboard_if #(.NREGS(NREGS), .IDXW(IDXW), .CNTW(CNTW), .NSRC(NSRC)) sb_if ();

    reg_scoreboard #(.NREGS(NREGS), .IDXW(IDXW), .CNTW(CNTW), .NSRC(NSRC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb_if)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cnt [NREGS];
    bit m_uf;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit tracked(input int i);
        return (i != 0) && (i < NREGS);
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] m = '0;
        for (int r = 0; r < NREGS; r++) m[r] = (cnt[r] != 0);
        return m;
    endfunction

    function automatic logic [31:0] m_pending();
        int s = 0;
        for (int r = 0; r < NREGS; r++) s += cnt[r];
        return s;
    endfunction

    task automatic clear_counts();
        for (int r = 0; r < NREGS; r++) cnt[r] = 0;
    endtask

    task automatic check_state(input string tag);
        check_val({tag, ".busy"},    {16'h0, sb_if.busy_mask},   m_busy());
        check_val({tag, ".pending"}, {25'h0, sb_if.pending},     m_pending());
        check_val({tag, ".uf"},      {31'h0, sb_if.underflow_err}, {31'h0, m_uf});
    endtask

    task automatic drive_idle();
        sb_if.issue_valid  = 1'b0;
        sb_if.issue_wr     = 1'b0;
        sb_if.issue_rt     = '0;
        sb_if.src_valid    = '0;
        sb_if.src_idx      = '0;
        sb_if.retire_valid = 1'b0;
        sb_if.retire_rt    = '0;
        sb_if.flush        = 1'b0;
    endtask

    // One cycle: apply inputs, check combinational stall, advance model, check state
    task automatic step(input bit iv, input bit wr, input int rt, input bit [1:0] sv,
                        input int s0, input int s1, input bit rv, input int rrt,
                        input bit fl, input string tag);
        bit st;
        bit acc;
        bit inc;
        bit dec;
        int srcs [2];
        @(negedge clk);
        sb_if.issue_valid  = iv;
        sb_if.issue_wr     = wr;
        sb_if.issue_rt     = IDXW'(rt);
        sb_if.src_valid    = sv;
        sb_if.src_idx      = {IDXW'(s1), IDXW'(s0)};
        sb_if.retire_valid = rv;
        sb_if.retire_rt    = IDXW'(rrt);
        sb_if.flush        = fl;
        srcs[0] = s0;
        srcs[1] = s1;
        st = 1'b0;
        if (iv) begin
            for (int k = 0; k < NSRC; k++)
                if (sv[k] && tracked(srcs[k]) && cnt[srcs[k]] != 0) st = 1'b1;
            if (wr && tracked(rt) && cnt[rt] == MAXC) st = 1'b1;
        end
        acc = iv && !st;
        #1;
        check_val({tag, ".stall"},  {31'h0, sb_if.stall},        {31'h0, st});
        check_val({tag, ".accept"}, {31'h0, sb_if.issue_accept}, {31'h0, acc});
        inc = acc && wr && tracked(rt);
        dec = rv && tracked(rrt) && cnt[rrt] != 0;
        if (rv && tracked(rrt) && cnt[rrt] == 0) m_uf = 1'b1;
        @(posedge clk);
        if (fl) begin
            clear_counts();
        end else begin
            if (inc) cnt[rt]++;
            if (dec) cnt[rrt]--;
        end
        #1;
        check_state(tag);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        drive_idle();
        #2 rst_n = 1'b0;
        clear_counts();
        m_uf = 1'b0;
        #1;
        check_state(tag);
        check_val({tag, ".stall"}, {31'h0, sb_if.stall}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int rnd_idx();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(0, NREGS - 1));
        return int'($urandom_range(0, 6));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive_idle();
        clear_counts();
        m_uf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        check_val("reset.stall",  {31'h0, sb_if.stall},        32'h0);
        check_val("reset.accept", {31'h0, sb_if.issue_accept}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        step(1, 1, 3, 2'b00, 0, 0, 0, 0, 0, "r3_issue");
        check_val("r3_busy_const", {16'h0, sb_if.busy_mask}, 32'h0008);
        check_val("r3_pend_const", {25'h0, sb_if.pending},   32'h1);
        step(1, 0, 0, 2'b01, 3, 0, 0, 0, 0, "r3_read");
        check_val("r3_stall_const", {31'h0, sb_if.stall}, 32'h1);
        step(0, 0, 0, 2'b00, 0, 0, 1, 3, 0, "r3_retire");

        step(1, 1, 5, 2'b00, 0, 0, 0, 0, 0, "r5_inc1");
        step(1, 1, 5, 2'b00, 0, 0, 0, 0, 0, "r5_inc2");
        step(1, 0, 0, 2'b10, 0, 5, 1, 5, 0, "r5_dec1");
        step(1, 0, 0, 2'b10, 0, 5, 1, 5, 0, "r5_dec2");
        step(1, 0, 0, 2'b10, 0, 5, 0, 0, 0, "r5_free");

        for (int i = 0; i < MAXC; i++) step(1, 1, 2, 2'b00, 0, 0, 0, 0, 0, "r2_fill");
        step(1, 1, 2, 2'b00, 0, 0, 0, 0, 0, "r2_sat");
        check_val("r2_sat_const", {31'h0, sb_if.stall}, 32'h1);
        step(0, 0, 0, 2'b00, 0, 0, 1, 2, 0, "r2_retire");
        step(1, 1, 2, 2'b00, 0, 0, 1, 2, 0, "r2_both");

        step(1, 1, 4, 2'b00, 0, 0, 0, 0, 0, "r4_inc");
        step(1, 1, 4, 2'b00, 0, 0, 1, 4, 0, "r4_both");

        step(1, 1, 1, 2'b00, 0, 0, 0, 0, 0, "ld_r1");
        step(1, 1, 6, 2'b00, 0, 0, 0, 0, 0, "ld_r6");
        step(1, 1, 7, 2'b00, 0, 0, 1, 1, 1, "flush");
        check_val("flush_busy_const", {16'h0, sb_if.busy_mask}, 32'h0);
        step(1, 0, 0, 2'b11, 7, 2, 0, 0, 0, "post_flush_read");

        step(0, 0, 0, 2'b00, 0, 0, 1, 9, 0, "r9_underflow");
        check_val("uf_const", {31'h0, sb_if.underflow_err}, 32'h1);
        step(1, 1, 0, 2'b11, 0, 0, 1, 0, 0, "r0_noop");
        async_reset("rst_uf");

        for (int i = 0; i < 600; i++) begin
            if (i == 300) async_reset("rst_mid");
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, rnd_idx(),
                 2'($urandom_range(0, 3)), rnd_idx(), rnd_idx(),
                 $urandom_range(0, 1) == 1, rnd_idx(), $urandom_range(0, 29) == 0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
